// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared encodings for the MEM-stage access unit.
`default_nettype none

package mem_access_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  localparam int WORD_BYTES = 4;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/byte_lane_unit.sv
// byte_lane_unit: load lane extraction/extension and sub-word store merge.
`default_nettype none

module byte_lane_unit
  import mem_access_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [31:0] rdata_i,
  input  logic [15:0] wdata_i,
  output logic [31:0] load_data_o,
  output logic [31:0] merge_data_o
);

  logic [4:0]  shamt_w;
  logic [15:0] lane_w;
  logic [31:0] mask_w;
  logic [31:0] ins_w;

  always_comb begin
    shamt_w      = 5'd0;
    lane_w       = 16'd0;
    mask_w       = 32'd0;
    ins_w        = 32'd0;
    load_data_o  = rdata_i;
    merge_data_o = rdata_i;

    // Halfwords live on lane addr[1]; bytes on lane addr[1:0].
    if (size_i == SIZE_HALF) begin
      shamt_w = {addr_lo_i[1], 4'b0000};
    end else begin
      shamt_w = {addr_lo_i, 3'b000};
    end
    lane_w = 16'(rdata_i >> shamt_w);

    case (size_i)
      SIZE_BYTE: begin
        load_data_o = {{24{signed_i & lane_w[7]}}, lane_w[7:0]};
        mask_w      = 32'h0000_00FF << shamt_w;
        ins_w       = {24'd0, wdata_i[7:0]} << shamt_w;
      end
      SIZE_HALF: begin
        load_data_o = {{16{signed_i & lane_w[15]}}, lane_w};
        mask_w      = 32'h0000_FFFF << shamt_w;
        ins_w       = {16'd0, wdata_i} << shamt_w;
      end
      default: begin
        load_data_o = rdata_i;
        mask_w      = 32'd0;
        ins_w       = 32'd0;
      end
    endcase

    merge_data_o = (rdata_i & ~mask_w) | ins_w;
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store controller in front of a word-addressed
// memory; sub-word stores run as a two-cycle read-modify-write.
`default_nettype none

module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int LITTLE_ENDIAN = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  stall,
  output logic [31:0]           load_data,
  output logic                  misalign,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  mem_read,
  output logic                  mem_write,
  input  logic [31:0]           mem_rdata
);

  localparam int OFFS_BITS = $clog2(WORD_BYTES);

  if (LITTLE_ENDIAN != 1) begin : g_endian_check
    $error("mem_access_unit: only LITTLE_ENDIAN=1 is supported");
  end

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           merge_q, merge_d;

  logic                  illegal_w;
  logic [ADDR_WIDTH-1:0] word_addr_w;
  logic [31:0]           lane_load_w;
  logic [31:0]           lane_merge_w;

  assign word_addr_w = {req_addr[ADDR_WIDTH-1:OFFS_BITS], {OFFS_BITS{1'b0}}};

  always_comb begin
    illegal_w = 1'b0;
    case (req_size)
      SIZE_HALF: illegal_w = req_addr[0];
      SIZE_WORD: illegal_w = (req_addr[1:0] != 2'b00);
      SIZE_ILL:  illegal_w = 1'b1;
      default:   illegal_w = 1'b0;
    endcase
  end

  byte_lane_unit u_byte_lane (
    .addr_lo_i    (req_addr[1:0]),
    .size_i       (req_size),
    .signed_i     (req_signed),
    .rdata_i      (mem_rdata),
    .wdata_i      (req_wdata[15:0]),
    .load_data_o  (lane_load_w),
    .merge_data_o (lane_merge_w)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      merge_q <= 32'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      merge_q <= merge_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    merge_d   = merge_q;
    stall     = 1'b0;
    misalign  = 1'b0;
    load_data = 32'd0;
    mem_addr  = word_addr_w;
    mem_wdata = req_wdata;
    mem_read  = 1'b0;
    mem_write = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          misalign = illegal_w;
          if (!illegal_w) begin
            if (!req_write) begin
              mem_read  = 1'b1;
              load_data = lane_load_w;
            end else if (req_size == SIZE_WORD) begin
              mem_write = 1'b1;
            end else begin
              // Register the merged word so the write cycle does not sit on
              // the memory read path.
              mem_read = 1'b1;
              stall    = 1'b1;
              merge_d  = lane_merge_w;
              addr_d   = word_addr_w;
              state_d  = RMW_WR;
            end
          end
        end
      end
      RMW_WR: begin
        mem_write = 1'b1;
        mem_wdata = merge_q;
        mem_addr  = addr_q;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (reset) begin
      stall     = 1'b0;
      misalign  = 1'b0;
      load_data = 32'd0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      state_d   = IDLE;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard-based bench with a behavioural word memory.
`default_nettype none

module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic [31:0] load_data;
  logic        misalign;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:63] = '{default: 32'd0};
  logic [31:0] exp_q [$];
  logic [31:0] exp_v;
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;
  end

  mem_access_unit #(.ADDR_WIDTH(32), .LITTLE_ENDIAN(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .stall      (stall),
    .load_data  (load_data),
    .misalign   (misalign),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_rdata  (mem_rdata)
  );

  task automatic drive(input logic v, input logic w, input logic [1:0] sz,
                       input logic sg, input logic [31:0] a, input logic [31:0] d);
    req_valid  = v;
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = d;
  endtask

  // Two-cycle sub-word store, stimulus only.
  task automatic rmw_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    drive(1'b1, 1'b1, sz, 1'b0, a, d);
    @(negedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h13, 32'd0);
    @(negedge clk); #1;
    if ({stall, misalign, mem_read, mem_write} !== 4'b0000) begin
      $display("FAIL reset_strobes_misaligned: got %b want 0000", {stall, misalign, mem_read, mem_write});
      n_fail++;
    end
    n_checks++;
    drive(1'b1, 1'b1, 2'b00, 1'b0, 32'h11, 32'hAB);
    #1;
    if ({stall, misalign, mem_read, mem_write} !== 4'b0000 || load_data !== 32'd0) begin
      $display("FAIL reset_strobes_store: got %b/%h want 0000/0", {stall, misalign, mem_read, mem_write}, load_data);
      n_fail++;
    end
    n_checks++;
    @(negedge clk);
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    reset = 1'b0;
  endtask

  task automatic test_word();
    @(negedge clk);
    drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'h12345678);
    exp_q.push_back(32'h12345678);
    #1;
    exp_v = exp_q.pop_front();
    if (!(mem_write === 1'b1 && mem_addr === 32'h10 && stall === 1'b0 && mem_read === 1'b0
          && mem_wdata === exp_v)) begin
      $display("FAIL sw: got wr=%b rd=%b addr=%h stall=%b wdata=%h want 1 0 10 0 %h",
               mem_write, mem_read, mem_addr, stall, mem_wdata, exp_v);
      n_fail++;
    end
    n_checks++;
    @(negedge clk);
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0);
    exp_q.push_back(32'h12345678);
    #1;
    exp_v = exp_q.pop_front();
    if (load_data !== exp_v || mem_read !== 1'b1 || stall !== 1'b0 || mem_write !== 1'b0) begin
      $display("FAIL lw: got data=%h rd=%b stall=%b wr=%b want %h 1 0 0", load_data, mem_read, stall, mem_write, exp_v);
      n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_subword_store();
    @(negedge clk);
    drive(1'b1, 1'b1, 2'b00, 1'b0, 32'h11, 32'hAB);
    exp_q.push_back(32'h1234AB78);
    #1;
    if ({stall, mem_read, mem_write} !== 3'b110) begin
      $display("FAIL sb_cycle0: got stall/rd/wr=%b want 110", {stall, mem_read, mem_write});
      n_fail++;
    end
    n_checks++;
    @(negedge clk); #1;
    exp_v = exp_q.pop_front();
    if (!(mem_write === 1'b1 && mem_read === 1'b0 && stall === 1'b0 && mem_addr === 32'h10
          && mem_wdata === exp_v)) begin
      $display("FAIL sb_cycle1: got wr=%b rd=%b stall=%b addr=%h wdata=%h want 1 0 0 10 %h",
               mem_write, mem_read, stall, mem_addr, mem_wdata, exp_v);
      n_fail++;
    end
    n_checks++;
    @(negedge clk);
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    if (mem[4] !== 32'h1234AB78) begin
      $display("FAIL sb_memword: got %h want 1234ab78", mem[4]);
      n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_loads();
    logic [31:0] addrs [4] = '{32'h11, 32'h11, 32'h12, 32'h10};
    logic [1:0]  sizes [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
    logic        sgns  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [31:0] exps  [4] = '{32'hFFFFFFAB, 32'h000000AB, 32'h00001234, 32'hFFFFAB78};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, sizes[i], sgns[i], addrs[i], 32'd0);
      exp_q.push_back(exps[i]);
      #1;
      exp_v = exp_q.pop_front();
      if (load_data !== exp_v || misalign !== 1'b0) begin
        $display("FAIL load_%0d: got %h mis=%b want %h 0", i, load_data, misalign, exp_v);
        n_fail++;
      end
      n_checks++;
    end
    rmw_store(2'b01, 32'h12, 32'h8001);
    @(negedge clk);
    drive(1'b1, 1'b0, 2'b01, 1'b1, 32'h12, 32'd0);
    exp_q.push_back(32'hFFFF8001);
    #1;
    exp_v = exp_q.pop_front();
    if (load_data !== exp_v) begin
      $display("FAIL lh_after_sh: got %h want %h", load_data, exp_v);
      n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_misalign();
    @(negedge clk);
    drive(1'b1, 1'b0, 2'b10, 1'b1, 32'h13, 32'd0);
    #1;
    if (!(misalign === 1'b1 && mem_read === 1'b0 && load_data === 32'd0 && stall === 1'b0)) begin
      $display("FAIL lw_misaligned: got mis=%b rd=%b data=%h stall=%b want 1 0 0 0", misalign, mem_read, load_data, stall);
      n_fail++;
    end
    n_checks++;
    @(negedge clk);
    drive(1'b1, 1'b1, 2'b01, 1'b0, 32'h11, 32'hBEEF);
    #1;
    if (!(misalign === 1'b1 && mem_write === 1'b0 && mem_read === 1'b0 && stall === 1'b0)) begin
      $display("FAIL sh_misaligned: got mis=%b wr=%b rd=%b stall=%b want 1 0 0 0", misalign, mem_write, mem_read, stall);
      n_fail++;
    end
    n_checks++;
    @(negedge clk);
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    #1;
    if (mem_write !== 1'b0 || mem[4] !== 32'h8001AB78) begin
      $display("FAIL sh_misaligned_after: got wr=%b word=%h want 0 8001ab78", mem_write, mem[4]);
      n_fail++;
    end
    n_checks++;
    @(negedge clk);
    drive(1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'd0);
    #1;
    if (!(misalign === 1'b1 && mem_read === 1'b0 && mem_write === 1'b0)) begin
      $display("FAIL size_illegal: got mis=%b rd=%b wr=%b want 1 0 0", misalign, mem_read, mem_write);
      n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_reset_rmw();
    @(negedge clk);
    drive(1'b1, 1'b1, 2'b00, 1'b0, 32'h20, 32'h55);
    @(negedge clk);
    reset = 1'b1;
    #1;
    if (mem_write !== 1'b0 || stall !== 1'b0) begin
      $display("FAIL reset_in_rmw: got wr=%b stall=%b want 0 0", mem_write, stall);
      n_fail++;
    end
    n_checks++;
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    if (mem[8] !== 32'd0) begin
      $display("FAIL reset_abandons_write: got %h want 00000000", mem[8]);
      n_fail++;
    end
    n_checks++;
    @(negedge clk);
    drive(1'b1, 1'b1, 2'b00, 1'b0, 32'h20, 32'h55);
    #1;
    if ({stall, mem_read, mem_write} !== 3'b110) begin
      $display("FAIL post_reset_sb: got stall/rd/wr=%b want 110", {stall, mem_read, mem_write});
      n_fail++;
    end
    n_checks++;
    @(negedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    if (mem[8] !== 32'h00000055) begin
      $display("FAIL post_reset_word: got %h want 00000055", mem[8]);
      n_fail++;
    end
    n_checks++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] stall_seen;
    logic [3:0] wr_seen;
    stall_seen = 4'd0;
    wr_seen    = 4'd0;
    exp_q.push_back(32'h00002211);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) drive(1'b1, 1'b1, 2'b00, 1'b0, 32'h30, 32'h11);
      if (c == 2) drive(1'b1, 1'b1, 2'b00, 1'b0, 32'h31, 32'h22);
      #1;
      stall_seen[c] = stall;
      wr_seen[c]    = mem_write;
    end
    if (stall_seen !== 4'b0101 || wr_seen !== 4'b1010) begin
      $display("FAIL b2b_pattern: got stall=%b wr=%b want 0101 1010", stall_seen, wr_seen);
      n_fail++;
    end
    n_checks++;
    @(negedge clk);
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h30, 32'd0);
    exp_v = exp_q.pop_front();
    if (mem[12] !== exp_v) begin
      $display("FAIL b2b_word: got %h want %h", mem[12], exp_v);
      n_fail++;
    end
    n_checks++;
    for (int c = 0; c < 3; c++) begin
      #1;
      if ({stall, misalign, mem_read, mem_write} !== 4'b0000 || load_data !== 32'd0) begin
        $display("FAIL idle_%0d: got %b/%h want 0000/0", c, {stall, misalign, mem_read, mem_write}, load_data);
        n_fail++;
      end
      n_checks++;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_subword_store();
    test_loads();
    test_misalign();
    test_reset_rmw();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
MEM-stage access controller sitting directly upstream of the word-addressed data memory: it turns pipeline load/store requests into word-level memory strobes.
- Loads: selects and sign/zero-extends byte, halfword or word from the returned memory word.
- Sub-word stores: performed as a two-cycle read-modify-write, with a stall to the pipeline.
- Misaligned or illegal requests are flagged and never reach memory.

Parameters:
ADDR_WIDTH, 32, request/memory byte-address width
LITTLE_ENDIAN, 1, byte 0 at bits [7:0]; only value 1 is supported, elaborate-time error otherwise

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high
req_valid  in  1  MEM-stage request present
req_write  in  1  1=store, 0=load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_signed  in  1  loads: 1 sign-extend, 0 zero-extend
req_addr  in  ADDR_WIDTH  byte address
req_wdata  in  32  store data, right-justified
stall  out  1  hold pipeline, request must stay stable
load_data  out  32  extended load result, same cycle
misalign  out  1  misaligned/illegal request, same cycle
mem_addr  out  ADDR_WIDTH  word-aligned address, [1:0]=00
mem_wdata  out  32  word to write
mem_read  out  1  memory read enable
mem_write  out  1  memory write enable, memory writes on posedge clk
mem_rdata  in  32  memory read data, combinational from mem_addr

Behaviour:
- Reset and clock: reset is asynchronous, active-high; clock is clk.
- Reset state:
  - state=IDLE; latched address and merged word registers = 0.
  - While reset is high, stall, misalign, mem_read and mem_write are forced 0, and load_data=0.
- Alignment: misalign=1 when req_valid and any of:
  - size=01 and addr[0]=1;
  - size=10 and addr[1:0]!=0;
  - size=11.
  - A misaligned request issues no mem_read/mem_write, gives stall=0 and load_data=0.
- mem_addr = {req_addr[ADDR_WIDTH-1:2],2'b00} in IDLE; latched address in RMW_WR.
- Load (IDLE, aligned): mem_read=1, no stall.
  - Byte: lane addr[1:0] (bits 8*lane+7:8*lane).
  - Half: lane addr[1] (bits 16*lane+15:16*lane).
  - Word: whole word.
  - Extension per req_signed; result valid combinationally in the same cycle.
- Word store (IDLE, aligned): single cycle; mem_write=1, mem_wdata=req_wdata, stall=0.
- Sub-word store, state machine:
  - IDLE:
    - mem_read=1, stall=1, mem_write=0.
    - Merged word = mem_rdata with the selected lane replaced by req_wdata[7:0] (byte) or req_wdata[15:0] (half).
    - Merged word and word address are registered; next state RMW_WR.
  - RMW_WR:
    - mem_write=1, mem_wdata=merged register, mem_addr=latched address, mem_read=0, stall=0.
    - Request inputs are ignored; next state IDLE unconditionally.
  - The registered merge breaks the read→merge→write combinational path. Total latency is 2 cycles; the pipeline advances at the end of the RMW_WR cycle.
- req_valid=0 in IDLE: all strobes 0, stall 0, load_data 0.
- Back-to-back sub-word stores: the second begins in the IDLE cycle after RMW_WR. Each store costs 2 cycles; no forwarding is needed because the write completes before the next read.
- Reset during RMW_WR: write is abandoned (mem_write forced 0), state returns to IDLE.
- No other state exists; any unreachable encoding decodes to IDLE.

Decomposition:
- Package mem_access_pkg holds:
  - size encodings SIZE_BYTE/SIZE_HALF/SIZE_WORD/SIZE_ILL;
  - state enum IDLE/RMW_WR;
  - helper constant WORD_BYTES=4.
- One combinational sub-module, byte_lane_unit, is natural. It does load extraction and store merge from (addr[1:0], size, signed, rdata, wdata).
- The FSM, registers and strobe muxing stay in mem_access_unit.

Test Plan:
1. Reset, sw 0x12345678 @0x10 → one cycle mem_write=1, mem_addr=0x10, stall=0; then lw @0x10 → load_data=0x12345678.
2. sb 0xAB @0x11 over 0x12345678 → cycle0: stall=1, mem_read=1, mem_write=0; cycle1: mem_write=1, mem_wdata=0x1234AB78, stall=0.
3. lb @0x11 → 0xFFFFFFAB; lbu @0x11 → 0x000000AB; lhu @0x12 → 0x00001234; sh 0x8001 @0x12 then lh @0x12 → 0xFFFF8001.
4. lw @0x13 → misalign=1, mem_read=0, load_data=0; sh @0x11 → misalign=1, mem_write stays 0, word unchanged; req_size=11 → misalign=1.
5. sb @0x20 with reset asserted in the RMW_WR cycle → mem_write=0 immediately, state IDLE, next request handled normally.
6. Back-to-back sb 0x11 @0x30, sb 0x22 @0x31 over 0 → 4 cycles, two stall pulses, final word 0x00002211; idle cycles with req_valid=0 → no strobes.
